// File: rtl/ccsds123_tb_pkg.sv
// rtl/ccsds123_tb_pkg.sv - shared constants, FSM encoding and LFSR step for the stall shaper
package ccsds123_tb_pkg;

  // Galois form of the x^32 + x^22 + x^2 + x^1 + 1 polynomial (right-shifting).
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } stall_state_e;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/axis_skid_fifo.sv
// rtl/axis_skid_fifo.sv - two-entry skid FIFO with registered storage
// Ports:
//   clk, reset        - clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_data    - write strobe and word; ignored while full
//   i_pop             - read strobe; ignored while empty
//   o_data            - head-of-queue word, stable until popped
//   o_full, o_empty   - occupancy flags
module axis_skid_fifo
  import ccsds123_tb_pkg::*;
#(
  parameter int DATA_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty
);

  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic                  w_push;
  logic                  w_pop;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      // Simultaneous push and pop leaves the occupancy untouched.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/axis_stall_shaper.sv
// rtl/axis_stall_shaper.sv - AXI-Stream stage injecting pseudo-random input bubbles and output stall bursts
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   s_axis_*                      - upstream stream (tdata/tvalid/tlast in, tready out)
//   m_axis_*                      - downstream stream (tdata/tvalid/tlast out, tready in)
//   in_mode                       - enable random input back-pressure
//   out_mode                      - enable random output stall bursts
//   stat_total/in_stall/out_valid - per-frame cycle, input-stall and output-beat counts of the last frame
//   stat_frames, stat_valid       - completed frame count and one-cycle update strobe
module axis_stall_shaper
  import ccsds123_tb_pkg::*;
#(
  parameter int          DATA_WIDTH    = 16,
  parameter int          CNT_WIDTH     = 32,
  parameter logic [31:0] SEED          = 32'h1,
  parameter int          IN_PASS_MOD   = 3,
  parameter int          OUT_STALL_MOD = 40,
  parameter int          BURST_MIN     = 20,
  parameter int          BURST_RANGE   = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  input  logic                  in_mode,
  input  logic                  out_mode,
  output logic [CNT_WIDTH-1:0]  stat_total,
  output logic [CNT_WIDTH-1:0]  stat_in_stall,
  output logic [CNT_WIDTH-1:0]  stat_out_valid,
  output logic [CNT_WIDTH-1:0]  stat_frames,
  output logic                  stat_valid
);

  localparam logic [31:0]          LP_IN_MOD      = 32'(IN_PASS_MOD);
  localparam logic [31:0]          LP_OUT_MOD     = 32'(OUT_STALL_MOD);
  localparam logic [31:0]          LP_BURST_MIN   = 32'(BURST_MIN);
  localparam logic [31:0]          LP_BURST_RANGE = 32'(BURST_RANGE);
  localparam logic [CNT_WIDTH-1:0] LP_CNT_MAX     = '1;
  localparam logic [CNT_WIDTH-1:0] LP_CNT_ONE     = CNT_WIDTH'(1);

  logic [31:0]           r_lfsr;
  stall_state_e          r_state;
  stall_state_e          w_state_nxt;
  logic [31:0]           r_burst_cnt;
  logic [31:0]           w_burst_nxt;
  logic                  w_out_stall;
  logic                  w_in_gate;
  logic                  w_full;
  logic                  w_empty;
  logic [DATA_WIDTH:0]   w_fifo_out;
  logic                  w_in_hs;
  logic                  w_out_hs;
  logic                  w_frame_end;

  logic [CNT_WIDTH-1:0]  r_total_cnt;
  logic [CNT_WIDTH-1:0]  r_in_stall_cnt;
  logic [CNT_WIDTH-1:0]  r_out_valid_cnt;
  logic [CNT_WIDTH-1:0]  w_total_inc;
  logic [CNT_WIDTH-1:0]  w_in_stall_inc;
  logic [CNT_WIDTH-1:0]  w_out_valid_inc;

  // Free-running LFSR; it advances whether or not either mode is enabled so
  // the shaping pattern depends only on time since reset.
  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= SEED;
    else       r_lfsr <= lfsr_step(r_lfsr);
  end

  assign w_in_gate = !in_mode || ((r_lfsr % LP_IN_MOD) == 32'd0);

  // Both handshake qualifiers are forced low while reset is held so nothing
  // transfers in the reset cycle itself.
  assign s_axis_tready = !reset && !w_full && w_in_gate;
  assign m_axis_tvalid = !reset && !w_empty && !w_out_stall;
  assign {m_axis_tlast, m_axis_tdata} = w_fifo_out;

  assign w_in_hs     = s_axis_tvalid && s_axis_tready;
  assign w_out_hs    = m_axis_tvalid && m_axis_tready;
  assign w_frame_end = w_out_hs && m_axis_tlast;

  axis_skid_fifo #(
    .DATA_WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_in_hs),
    .i_data  ({s_axis_tlast, s_axis_tdata}),
    .i_pop   (w_out_hs),
    .o_data  (w_fifo_out),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Output stall FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_burst_cnt <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_nxt;
    end
  end

  // Output stall FSM: next state. The burst counter is loaded with length-1
  // so the STALL state lasts exactly the drawn number of cycles. out_mode is
  // only consulted in IDLE, so a running burst always completes.
  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = r_burst_cnt;
    case (r_state)
      ST_IDLE: begin
        if (out_mode && ((r_lfsr % LP_OUT_MOD) == 32'd0)) begin
          w_state_nxt = ST_STALL;
          w_burst_nxt = LP_BURST_MIN + (r_lfsr % LP_BURST_RANGE) - 32'd1;
        end
      end
      ST_STALL: begin
        if (r_burst_cnt == 32'd0) w_state_nxt = ST_IDLE;
        else                      w_burst_nxt = r_burst_cnt - 32'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output stall FSM: outputs.
  always_comb begin
    w_out_stall = (r_state == ST_STALL);
  end

  // Saturating per-frame increments; these are also the values published on
  // a frame end so that the final cycle of the frame is included.
  assign w_total_inc     = (r_total_cnt == LP_CNT_MAX) ? r_total_cnt : r_total_cnt + LP_CNT_ONE;
  assign w_in_stall_inc  = (s_axis_tvalid && !s_axis_tready && (r_in_stall_cnt != LP_CNT_MAX))
                           ? r_in_stall_cnt + LP_CNT_ONE : r_in_stall_cnt;
  assign w_out_valid_inc = (w_out_hs && (r_out_valid_cnt != LP_CNT_MAX))
                           ? r_out_valid_cnt + LP_CNT_ONE : r_out_valid_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_total_cnt     <= '0;
      r_in_stall_cnt  <= '0;
      r_out_valid_cnt <= '0;
      stat_total      <= '0;
      stat_in_stall   <= '0;
      stat_out_valid  <= '0;
      stat_frames     <= '0;
      stat_valid      <= 1'b0;
    end else if (w_frame_end) begin
      stat_total      <= w_total_inc;
      stat_in_stall   <= w_in_stall_inc;
      stat_out_valid  <= w_out_valid_inc;
      stat_frames     <= stat_frames + LP_CNT_ONE;
      stat_valid      <= 1'b1;
      r_total_cnt     <= '0;
      r_in_stall_cnt  <= '0;
      r_out_valid_cnt <= '0;
    end else begin
      r_total_cnt     <= w_total_inc;
      r_in_stall_cnt  <= w_in_stall_inc;
      r_out_valid_cnt <= w_out_valid_inc;
      stat_valid      <= 1'b0;
    end
  end

endmodule
